// File: rtl/micro_sequencer.sv
// Microprogram sequencer: produces the registered micro-program counter from
// the current microinstruction's sequencing opcode, the selected branch
// condition and a small LIFO return stack for subroutine call/return.
module micro_sequencer #(
  parameter int AW         = 8,
  parameter int DEPTH      = 4,
  parameter int RESET_ADDR = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          stall,
  input  logic [2:0]    seq_op,
  input  logic          cond,
  input  logic [AW-1:0] br_addr,
  input  logic [AW-1:0] map_addr,
  input  logic          clr_err,
  output logic [AW-1:0] upc,
  output logic [4:0]    stk_depth,
  output logic          stk_ovf,
  output logic          stk_unf
);

  localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] RST_UPC = AW'(RESET_ADDR);
  localparam logic [4:0]    DEPTH_V = 5'(DEPTH);

  typedef enum logic [2:0] {
    OP_NEXT     = 3'd0,
    OP_BRANCH   = 3'd1,
    OP_CALL     = 3'd2,
    OP_RET      = 3'd3,
    OP_DISPATCH = 3'd4,
    OP_WAIT     = 3'd5,
    OP_RESTART  = 3'd6,
    OP_RSVD     = 3'd7
  } op_e;

  logic [AW-1:0] r_upc;
  logic [4:0]    r_depth;
  logic          r_ovf;
  logic          r_unf;
  logic [AW-1:0] r_stack [DEPTH];

  op_e           w_op;
  logic [AW-1:0] w_upc_inc;
  logic [AW-1:0] w_upc_nxt;
  logic [AW-1:0] w_top;
  logic [IW-1:0] w_push_idx;
  logic [IW-1:0] w_top_idx;
  logic          w_push;
  logic          w_pop;
  logic          w_clr_depth;
  logic          w_ovf_set;
  logic          w_unf_set;
  logic          w_full;
  logic          w_empty;

  assign w_op       = op_e'(seq_op);
  assign w_upc_inc  = r_upc + AW'(1);
  assign w_full     = (r_depth >= DEPTH_V);
  assign w_empty    = (r_depth == 5'd0);
  assign w_push_idx = IW'(r_depth);
  assign w_top_idx  = IW'(r_depth - 5'd1);
  assign w_top      = r_stack[w_top_idx];

  // Next-address selection and stack/flag event decode for the current opcode.
  always_comb begin
    w_upc_nxt   = w_upc_inc;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_clr_depth = 1'b0;
    w_ovf_set   = 1'b0;
    w_unf_set   = 1'b0;
    case (w_op)
      OP_BRANCH: begin
        if (cond) w_upc_nxt = br_addr;
      end
      OP_CALL: begin
        if (cond) begin
          if (!w_full) begin
            w_push    = 1'b1;
            w_upc_nxt = br_addr;
          end else begin
            w_ovf_set = 1'b1;
          end
        end
      end
      OP_RET: begin
        if (cond) begin
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_upc_nxt = w_top;
          end else begin
            w_unf_set = 1'b1;
          end
        end
      end
      OP_DISPATCH: w_upc_nxt = map_addr;
      OP_WAIT: begin
        if (!cond) w_upc_nxt = r_upc;
      end
      OP_RESTART: begin
        w_upc_nxt   = RST_UPC;
        w_clr_depth = 1'b1;
      end
      default: w_upc_nxt = w_upc_inc;
    endcase
  end

  // Sequencer state: upc, stack depth and sticky error flags; stall freezes all.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_upc   <= RST_UPC;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (!stall) begin
      r_upc <= w_upc_nxt;
      if (w_clr_depth)  r_depth <= '0;
      else if (w_push)  r_depth <= r_depth + 5'd1;
      else if (w_pop)   r_depth <= r_depth - 5'd1;
      // set takes priority over a coincident clear
      if (w_ovf_set)    r_ovf <= 1'b1;
      else if (clr_err) r_ovf <= 1'b0;
      if (w_unf_set)    r_unf <= 1'b1;
      else if (clr_err) r_unf <= 1'b0;
    end
  end

  // Return-stack storage; contents need no reset since depth gates every read.
  always_ff @(posedge clk) begin
    if (!stall && w_push) r_stack[w_push_idx] <= w_upc_inc;
  end

  assign upc       = r_upc;
  assign stk_depth = r_depth;
  assign stk_ovf   = r_ovf;
  assign stk_unf   = r_unf;

endmodule

// File: tb/tb_micro_sequencer.sv
module tb_micro_sequencer;

  logic       clk;
  logic       reset_n;
  logic       stall;
  logic [2:0] seq_op;
  logic       cond;
  logic [7:0] br_addr;
  logic [7:0] map_addr;
  logic       clr_err;
  logic [7:0] upc;
  logic [4:0] stk_depth;
  logic       stk_ovf;
  logic       stk_unf;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [2:0] NEXT = 3'd0, BRANCH = 3'd1, CALL = 3'd2, RET = 3'd3,
                         DISP = 3'd4, WAITC = 3'd5, RESTART = 3'd6;

  micro_sequencer #(.AW(8), .DEPTH(4), .RESET_ADDR(0)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .seq_op(seq_op), .cond(cond),
    .br_addr(br_addr), .map_addr(map_addr), .clr_err(clr_err),
    .upc(upc), .stk_depth(stk_depth), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setop(input logic [2:0] op, input logic c, input logic [7:0] ba, input logic [7:0] ma);
    seq_op = op; cond = c; br_addr = ba; map_addr = ma;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] eu, input logic [4:0] ed,
                         input logic eo, input logic eun);
    chk({tag, ".upc"}, 32'(upc), 32'(eu));
    chk({tag, ".depth"}, 32'(stk_depth), 32'(ed));
    chk({tag, ".ovf"}, 32'(stk_ovf), 32'(eo));
    chk({tag, ".unf"}, 32'(stk_unf), 32'(eun));
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; clr_err = 1'b0;
    setop(NEXT, 1'b0, 8'h00, 8'h00);
    #12;
    chk_all("reset", 8'h00, 5'd0, 1'b0, 1'b0);
    reset_n = 1'b1;

    // move mid-program, then reset asynchronously
    setop(DISP, 1'b0, 8'h00, 8'h55);
    tick(); chk("disp55", 32'(upc), 32'h55);
    setop(NEXT, 1'b0, 8'h00, 8'h00);
    #2 reset_n = 1'b0;
    #1 chk("rst_mid", 32'(upc), 32'h00);
    @(negedge clk) reset_n = 1'b1;
    tick(); chk("next1", 32'(upc), 32'h01);
    tick(); chk("next2", 32'(upc), 32'h02);
    tick(); chk("next3", 32'(upc), 32'h03);

    // wrap from all-ones
    setop(DISP, 1'b0, 8'h00, 8'hFF); tick(); chk("dispFF", 32'(upc), 32'hFF);
    setop(NEXT, 1'b0, 8'h00, 8'h00); tick(); chk_all("wrap", 8'h00, 5'd0, 1'b0, 1'b0);

    // branch
    setop(DISP, 1'b0, 8'h00, 8'h10); tick();
    setop(BRANCH, 1'b0, 8'h40, 8'h00); tick(); chk("br_nt", 32'(upc), 32'h11);
    setop(BRANCH, 1'b1, 8'h40, 8'h00); tick(); chk("br_t", 32'(upc), 32'h40);
    stall = 1'b1;
    setop(BRANCH, 1'b1, 8'h77, 8'h00); tick(); chk("stall1", 32'(upc), 32'h40);
    tick(); chk("stall2", 32'(upc), 32'h40);
    setop(RET, 1'b1, 8'h00, 8'h00); tick(); chk_all("stall_ret", 8'h40, 5'd0, 1'b0, 1'b0);
    stall = 1'b0;

    // nested calls to full depth
    setop(DISP, 1'b0, 8'h00, 8'h20); tick();
    for (int k = 0; k < 4; k++) begin
      setop(CALL, 1'b1, 8'(8'h21 + k), 8'h00); tick();
      chk("call_upc", 32'(upc), 32'(8'h21 + k));
      chk("call_depth", 32'(stk_depth), 32'(k + 1));
    end
    setop(CALL, 1'b1, 8'h60, 8'h00); tick(); chk_all("call_ovf", 8'h25, 5'd4, 1'b1, 1'b0);
    setop(RET, 1'b1, 8'h00, 8'h00); tick(); chk_all("ret1", 8'h24, 5'd3, 1'b1, 1'b0);
    tick(); chk_all("ret2", 8'h23, 5'd2, 1'b1, 1'b0);
    tick(); chk_all("ret3", 8'h22, 5'd1, 1'b1, 1'b0);
    tick(); chk_all("ret4", 8'h21, 5'd0, 1'b1, 1'b0);
    tick(); chk_all("ret_unf", 8'h22, 5'd0, 1'b1, 1'b1);
    setop(CALL, 1'b0, 8'h60, 8'h00); tick(); chk_all("call_nt", 8'h23, 5'd0, 1'b1, 1'b1);

    // wait and dispatch
    setop(DISP, 1'b0, 8'h00, 8'h30); tick();
    setop(WAITC, 1'b0, 8'h99, 8'h00);
    for (int i = 0; i < 5; i++) begin
      tick(); chk("wait_hold", 32'(upc), 32'h30);
    end
    setop(WAITC, 1'b1, 8'h99, 8'h00); tick(); chk("wait_go", 32'(upc), 32'h31);
    setop(DISP, 1'b0, 8'h00, 8'h80); tick(); chk("disp80", 32'(upc), 32'h80);

    // restart after two calls; flags untouched
    setop(CALL, 1'b1, 8'h70, 8'h00); tick();
    setop(CALL, 1'b1, 8'h90, 8'h00); tick(); chk_all("call2", 8'h90, 5'd2, 1'b1, 1'b1);
    setop(RESTART, 1'b0, 8'h00, 8'h00); tick(); chk_all("restart", 8'h00, 5'd0, 1'b1, 1'b1);

    // clear under stall holds, then clear
    stall = 1'b1; clr_err = 1'b1; setop(NEXT, 1'b0, 8'h00, 8'h00);
    tick(); chk_all("clr_stall", 8'h00, 5'd0, 1'b1, 1'b1);
    stall = 1'b0;
    tick(); chk_all("clr", 8'h01, 5'd0, 1'b0, 1'b0);
    clr_err = 1'b0;

    // fill stack, then overflow with coincident clear
    setop(CALL, 1'b1, 8'h10, 8'h00);
    for (int i = 0; i < 4; i++) tick();
    chk_all("fill", 8'h10, 5'd4, 1'b0, 1'b0);
    clr_err = 1'b1; tick(); chk_all("set_wins", 8'h11, 5'd4, 1'b1, 1'b0);
    clr_err = 1'b0;

    // async reset between edges during call chain
    #3 reset_n = 1'b0;
    #1 chk_all("async_rst", 8'h00, 5'd0, 1'b0, 1'b0);
    @(negedge clk) reset_n = 1'b1;
    setop(NEXT, 1'b0, 8'h00, 8'h00); tick(); chk("post_rst", 32'(upc), 32'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
